// File: rtl/axi4_lite_master_exerciser_if.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_master_exerciser_if
// Purpose  : AXI4-Lite bus bundle between the exerciser master and its slave
//            memory. Member names carry the master's point of view (o_ driven
//            by the master, i_ driven by the slave).
// Revision : 1.0 - initial release
// ============================================================================
interface axi4_lite_master_exerciser_if;
  logic        o_alm_awvalid;
  logic        i_alm_awready;
  logic [6:0]  o_alm_awaddr;
  logic        o_alm_wvalid;
  logic        i_alm_wready;
  logic [31:0] o_alm_wdata;
  logic [3:0]  o_alm_wstrb;
  logic [1:0]  i_alm_bresp;
  logic        i_alm_bvalid;
  logic        o_alm_bready;
  logic        o_alm_arvalid;
  logic        i_alm_arready;
  logic [6:0]  o_alm_araddr;
  logic        i_alm_rvalid;
  logic        o_alm_rready;
  logic [31:0] i_alm_rdata;
  logic [1:0]  i_alm_rresp;

  modport master (
    output o_alm_awvalid, o_alm_awaddr, o_alm_wvalid, o_alm_wdata, o_alm_wstrb,
           o_alm_bready, o_alm_arvalid, o_alm_araddr, o_alm_rready,
    input  i_alm_awready, i_alm_wready, i_alm_bresp, i_alm_bvalid,
           i_alm_arready, i_alm_rvalid, i_alm_rdata, i_alm_rresp
  );

  modport slave (
    input  o_alm_awvalid, o_alm_awaddr, o_alm_wvalid, o_alm_wdata, o_alm_wstrb,
           o_alm_bready, o_alm_arvalid, o_alm_araddr, o_alm_rready,
    output i_alm_awready, i_alm_wready, i_alm_bresp, i_alm_bvalid,
           i_alm_arready, i_alm_rvalid, i_alm_rdata, i_alm_rresp
  );
endinterface
`default_nettype wire

// File: rtl/axi4_lite_master_exerciser.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_master_exerciser
// Purpose  : Hard-wired AXI4-Lite master. Writes an incrementing byte pattern
//            to P_WORDS words, overlays a strobed partial write on word 4,
//            reads every word back and streams the bytes out, followed by a
//            saturating error-count status byte. Then holds o_done.
// Revision : 1.0 - initial release
// ============================================================================
module axi4_lite_master_exerciser #(
  parameter int P_WORDS = 32
) (
  input  logic                                i_alm_aclk,
  input  logic                                i_alm_aresetn,
  axi4_lite_master_exerciser_if.master        alm,
  output logic [7:0]                          o_diag_data,
  output logic                                o_diag_wr,
  output logic                                o_done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_REQ  = 3'd1,
    S_WR_RESP = 3'd2,
    S_RD_REQ  = 3'd3,
    S_RD_DATA = 3'd4,
    S_EMIT    = 3'd5,
    S_STATUS  = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  // Write index P_WORDS is the extra partial write that follows the fill.
  localparam logic [5:0] c_PARTIAL = 6'(P_WORDS);
  localparam logic [5:0] c_LAST    = 6'(P_WORDS - 1);

  state_t      r_state;
  logic [5:0]  r_k;
  logic [1:0]  r_byte;
  logic [31:0] r_rdata;
  logic [7:0]  r_err;

  logic        r_awvalid;
  logic [6:0]  r_awaddr;
  logic        r_wvalid;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_bready;
  logic        r_arvalid;
  logic [6:0]  r_araddr;
  logic        r_rready;
  logic [7:0]  r_diag_data;
  logic        r_diag_wr;
  logic        r_done;

  // Fill pattern: byte j of word k holds 4k+j.
  function automatic logic [31:0] f_word(input logic [5:0] k);
    logic [7:0] b;
    b = {k, 2'b00};
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  logic [5:0]  w_nk;
  logic [6:0]  w_nxt_addr;
  logic [31:0] w_nxt_wdata;
  logic [3:0]  w_nxt_wstrb;
  logic [7:0]  w_err_inc;
  logic [7:0]  w_emit_byte;
  logic        w_aw_ok;
  logic        w_w_ok;

  assign w_nk        = r_k + 6'd1;
  assign w_nxt_addr  = (w_nk == c_PARTIAL) ? 7'h10 : {w_nk[4:0], 2'b00};
  assign w_nxt_wdata = (w_nk == c_PARTIAL) ? 32'hDEAD_BEEF : f_word(w_nk);
  assign w_nxt_wstrb = (w_nk == c_PARTIAL) ? 4'b0101 : 4'hF;
  assign w_err_inc   = (r_err == 8'hFF) ? r_err : r_err + 8'd1;
  assign w_emit_byte = r_rdata[{r_byte, 3'b000} +: 8];
  // A channel counts as accepted if already dropped or handshaking now.
  assign w_aw_ok     = !r_awvalid || alm.i_alm_awready;
  assign w_w_ok      = !r_wvalid  || alm.i_alm_wready;

  // Sequencer: every bus and diagnostic output is a register set here.
  always_ff @(posedge i_alm_aclk or negedge i_alm_aresetn) begin
    if (!i_alm_aresetn) begin
      r_state     <= S_IDLE;
      r_k         <= 6'd0;
      r_byte      <= 2'd0;
      r_rdata     <= 32'd0;
      r_err       <= 8'd0;
      r_awvalid   <= 1'b0;
      r_awaddr    <= 7'd0;
      r_wvalid    <= 1'b0;
      r_wdata     <= 32'd0;
      r_wstrb     <= 4'd0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_araddr    <= 7'd0;
      r_rready    <= 1'b0;
      r_diag_data <= 8'd0;
      r_diag_wr   <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_diag_wr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_k       <= 6'd0;
          r_awvalid <= 1'b1;
          r_wvalid  <= 1'b1;
          r_awaddr  <= 7'd0;
          r_wdata   <= f_word(6'd0);
          r_wstrb   <= 4'hF;
          r_state   <= S_WR_REQ;
        end
        S_WR_REQ: begin
          if (r_awvalid && alm.i_alm_awready) r_awvalid <= 1'b0;
          if (r_wvalid && alm.i_alm_wready)   r_wvalid  <= 1'b0;
          if (w_aw_ok && w_w_ok) begin
            r_bready <= 1'b1;
            r_state  <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (alm.i_alm_bvalid) begin
            r_bready <= 1'b0;
            if (alm.i_alm_bresp != 2'b00) r_err <= w_err_inc;
            if (r_k == c_PARTIAL) begin
              r_k       <= 6'd0;
              r_araddr  <= 7'd0;
              r_arvalid <= 1'b1;
              r_state   <= S_RD_REQ;
            end else begin
              r_k       <= w_nk;
              r_awaddr  <= w_nxt_addr;
              r_wdata   <= w_nxt_wdata;
              r_wstrb   <= w_nxt_wstrb;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= S_WR_REQ;
            end
          end
        end
        S_RD_REQ: begin
          if (alm.i_alm_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (alm.i_alm_rvalid) begin
            r_rready    <= 1'b0;
            r_rdata     <= alm.i_alm_rdata;
            if (alm.i_alm_rresp != 2'b00) r_err <= w_err_inc;
            // Byte 0 goes out straight from the bus so EMIT spans 4 cycles.
            r_diag_data <= alm.i_alm_rdata[7:0];
            r_diag_wr   <= 1'b1;
            r_byte      <= 2'd1;
            r_state     <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (r_byte != 2'd0) begin
            r_diag_data <= w_emit_byte;
            r_diag_wr   <= 1'b1;
            r_byte      <= r_byte + 2'd1;
          end else if (r_k == c_LAST) begin
            r_diag_data <= r_err;
            r_diag_wr   <= 1'b1;
            r_state     <= S_STATUS;
          end else begin
            r_k       <= w_nk;
            r_araddr  <= {w_nk[4:0], 2'b00};
            r_arvalid <= 1'b1;
            r_state   <= S_RD_REQ;
          end
        end
        S_STATUS: begin
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_done <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign alm.o_alm_awvalid = r_awvalid;
  assign alm.o_alm_awaddr  = r_awaddr;
  assign alm.o_alm_wvalid  = r_wvalid;
  assign alm.o_alm_wdata   = r_wdata;
  assign alm.o_alm_wstrb   = r_wstrb;
  assign alm.o_alm_bready  = r_bready;
  assign alm.o_alm_arvalid = r_arvalid;
  assign alm.o_alm_araddr  = r_araddr;
  assign alm.o_alm_rready  = r_rready;
  assign o_diag_data       = r_diag_data;
  assign o_diag_wr         = r_diag_wr;
  assign o_done            = r_done;

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_master_exerciser.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4_lite_master_exerciser
// Purpose  : Bench for the AXI4-Lite exerciser with a behavioural slave memory
//            offering registered, zero-wait and skewed readiness, response
//            error injection and a write-response stall.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi4_lite_master_exerciser;

  localparam int W = 32;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  axi4_lite_master_exerciser_if bus();
  logic [7:0] diag_data;
  logic       diag_wr;
  logic       done;

  axi4_lite_master_exerciser #(.P_WORDS(W)) dut (
    .i_alm_aclk    (clk),
    .i_alm_aresetn (rstn),
    .alm           (bus),
    .o_diag_data   (diag_data),
    .o_diag_wr     (diag_wr),
    .o_done        (done)
  );

  // Scenario knobs, written only by the stimulus process.
  int mode      = 0;   // 0 registered ready, 1 ready tied high, 2 skewed wready
  int stall_len = 0;   // bvalid hold-off on write 0
  bit inj       = 1'b0;
  bit clr_mem   = 1'b1;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] f_word(input int k);
    logic [7:0] b;
    b = 8'(4 * k);
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  // Final memory word: word 4 carries the 0101-strobed DEADBEEF overlay.
  function automatic logic [31:0] exp_word(input int k);
    if (k == 4) return 32'h13AD_11EF;
    return f_word(k);
  endfunction

  function automatic logic [31:0] exp_wdata(input int n);
    if (n == W) return 32'hDEAD_BEEF;
    return f_word(n);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r;
    for (int j = 0; j < 4; j++) r[8*j +: 8] = s[j] ? n[8*j +: 8] : o[8*j +: 8];
    return r;
  endfunction

  // ---------------- slave memory model ----------------
  logic [31:0] mem [0:31];
  logic        s_awready, s_wready, s_arready, s_bvalid, s_rvalid;
  logic [1:0]  s_bresp, s_rresp;
  logic [31:0] s_rdata;
  logic        aw_got, w_got, ar_got;
  logic [6:0]  aw_a, ar_a;
  logic [31:0] w_d;
  logic [3:0]  w_s;
  int          wr_cnt, rd_cnt, skew, stall_cnt;

  assign bus.i_alm_awready = (mode == 1) ? 1'b1 : s_awready;
  assign bus.i_alm_wready  = (mode == 1) ? 1'b1 : s_wready;
  assign bus.i_alm_arready = (mode == 1) ? 1'b1 : s_arready;
  assign bus.i_alm_bvalid  = s_bvalid;
  assign bus.i_alm_bresp   = s_bresp;
  assign bus.i_alm_rvalid  = s_rvalid;
  assign bus.i_alm_rdata   = s_rdata;
  assign bus.i_alm_rresp   = s_rresp;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s_awready <= 1'b0; s_wready <= 1'b0; s_arready <= 1'b0;
      s_bvalid  <= 1'b0; s_rvalid <= 1'b0;
      s_bresp   <= 2'b00; s_rresp <= 2'b00; s_rdata <= 32'd0;
      aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
      aw_a <= 7'd0; ar_a <= 7'd0; w_d <= 32'd0; w_s <= 4'd0;
      wr_cnt <= 0; rd_cnt <= 0; skew <= 0; stall_cnt <= stall_len;
      if (clr_mem) for (int i = 0; i < 32; i++) mem[i] <= 32'd0;
    end else begin
      s_awready <= bus.o_alm_awvalid && !bus.i_alm_awready;
      s_arready <= bus.o_alm_arvalid && !bus.i_alm_arready;
      if (mode == 2)
        s_wready <= bus.o_alm_wvalid && !bus.i_alm_wready && aw_got && (skew >= 4);
      else
        s_wready <= bus.o_alm_wvalid && !bus.i_alm_wready;
      if (aw_got && !w_got) skew <= skew + 1;

      if (bus.o_alm_awvalid && bus.i_alm_awready) begin aw_got <= 1'b1; aw_a <= bus.o_alm_awaddr; end
      if (bus.o_alm_wvalid && bus.i_alm_wready) begin
        w_got <= 1'b1; w_d <= bus.o_alm_wdata; w_s <= bus.o_alm_wstrb;
      end
      if (aw_got && w_got && !s_bvalid) begin
        if (stall_cnt != 0) stall_cnt <= stall_cnt - 1;
        else begin
          mem[aw_a[6:2]] <= merge(mem[aw_a[6:2]], w_d, w_s);
          s_bvalid <= 1'b1;
          s_bresp  <= (inj && wr_cnt < 2) ? 2'b10 : 2'b00;
        end
      end
      if (s_bvalid && bus.o_alm_bready) begin
        s_bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; skew <= 0; wr_cnt <= wr_cnt + 1;
      end

      if (bus.o_alm_arvalid && bus.i_alm_arready) begin ar_got <= 1'b1; ar_a <= bus.o_alm_araddr; end
      if (ar_got && !s_rvalid) begin
        s_rvalid <= 1'b1;
        s_rdata  <= mem[ar_a[6:2]];
        s_rresp  <= (inj && rd_cnt == 2) ? 2'b11 : 2'b00;
      end
      if (s_rvalid && bus.o_alm_rready) begin
        s_rvalid <= 1'b0; ar_got <= 1'b0; rd_cnt <= rd_cnt + 1;
      end
    end
  end

  // ---------------- monitor (opposite edge) ----------------
  logic [7:0] diag_q [0:255];
  int n_diag, awv_cyc, wv_cyc, arv_cyc, w_alone, w_unstable, stall_seen, stall_bad;

  always @(negedge clk) begin
    if (!rstn) begin
      n_diag = 0; awv_cyc = 0; wv_cyc = 0; arv_cyc = 0;
      w_alone = 0; w_unstable = 0; stall_seen = 0; stall_bad = 0;
    end else begin
      if (diag_wr) begin
        if (n_diag < 256) diag_q[n_diag] = diag_data;
        n_diag++;
      end
      if (bus.o_alm_awvalid) awv_cyc++;
      if (bus.o_alm_wvalid)  wv_cyc++;
      if (bus.o_alm_arvalid) arv_cyc++;
      if (mode == 2 && bus.o_alm_wvalid && !bus.o_alm_awvalid) begin
        w_alone++;
        if (bus.o_alm_wdata !== exp_wdata(wr_cnt)) w_unstable++;
      end
      if (aw_got && w_got && !s_bvalid && stall_cnt != 0) begin
        stall_seen++;
        if (!bus.o_alm_bready || bus.o_alm_awvalid || diag_wr) stall_bad++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic apply_reset();
    #1 rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic release_and_run(input string tag);
    int cyc;
    rstn = 1'b1;
    @(posedge clk); #1;
    check({tag, ":start_valids"}, {30'd0, bus.o_alm_awvalid, bus.o_alm_wvalid}, 32'd3);
    cyc = 0;
    while (!done && cyc < 5000) begin @(negedge clk); cyc++; end
    check({tag, ":done"}, {31'd0, done}, 32'd1);
  endtask

  task automatic check_stream(input string tag, input logic [7:0] status);
    check({tag, ":len"}, n_diag, 4 * W + 1);
    for (int k = 0; k < W; k++)
      check($sformatf("%s:word%0d", tag, k),
            {diag_q[4*k+3], diag_q[4*k+2], diag_q[4*k+1], diag_q[4*k]}, exp_word(k));
    check({tag, ":status"}, {24'd0, diag_q[4*W]}, {24'd0, status});
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, ":ctl"}, {25'd0, bus.o_alm_awvalid, bus.o_alm_wvalid, bus.o_alm_bready,
                          bus.o_alm_arvalid, bus.o_alm_rready, diag_wr, done}, 32'd0);
    check({tag, ":wdata"}, bus.o_alm_wdata, 32'd0);
    check({tag, ":addr"}, {6'd0, bus.o_alm_awaddr, bus.o_alm_araddr, bus.o_alm_wstrb, diag_data}, 32'd0);
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int cyc;

    // Baseline: registered-ready slave.
    mode = 0; stall_len = 0; inj = 1'b0; clr_mem = 1'b1;
    apply_reset();
    check_outputs_zero("reset");
    release_and_run("base");
    check_stream("base", 8'h00);
    repeat (10) @(negedge clk);
    check("base:done_hold", {25'd0, done, bus.o_alm_awvalid, bus.o_alm_wvalid, bus.o_alm_arvalid,
                             bus.o_alm_bready, bus.o_alm_rready, diag_wr}, 32'h40);

    // Zero-wait slave: each valid lives exactly one cycle per transaction.
    mode = 1;
    apply_reset();
    release_and_run("zw");
    check_stream("zw", 8'h00);
    check("zw:awvalid_cycles", awv_cyc, W + 1);
    check("zw:wvalid_cycles",  wv_cyc,  W + 1);
    check("zw:arvalid_cycles", arv_cyc, W);

    // Skewed wready against a cleared memory.
    mode = 2; clr_mem = 1'b1;
    apply_reset();
    release_and_run("skew");
    check_stream("skew", 8'h00);
    check("skew:w_alone_seen", {31'd0, w_alone > 0}, 32'd1);
    check("skew:w_stable", w_unstable, 32'd0);
    for (int k = 0; k < W; k++) check($sformatf("skew:mem%0d", k), mem[k], exp_word(k));

    // Error injection on writes 0,1 and read 2.
    mode = 0; inj = 1'b1;
    apply_reset();
    release_and_run("err");
    check_stream("err", 8'h03);
    inj = 1'b0;

    // Reset in the middle of a read data phase.
    apply_reset();
    rstn = 1'b1;
    cyc = 0;
    while (!bus.o_alm_rready && cyc < 2000) begin @(negedge clk); cyc++; end
    check("midrst:reached_rd_data", {31'd0, bus.o_alm_rready}, 32'd1);
    #1 rstn = 1'b0;
    #1 check_outputs_zero("midrst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    release_and_run("rerun");
    check_stream("rerun", 8'h00);

    // bvalid held off for 100 cycles on the first write.
    stall_len = 100;
    apply_reset();
    release_and_run("stall");
    check("stall:cycles", stall_seen, 32'd100);
    check("stall:violations", stall_bad, 32'd0);
    check_stream("stall", 8'h00);
    stall_len = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
